// File: rtl/router_defs.sv
// Shared definitions for the router packet transmitter: header field widths,
// FSM state encodings and header/parity helpers.
package router_defs;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_PARITY  = 3'd4,
    ST_DONE    = 3'd5
  } tx_state_t;

  function automatic logic [7:0] make_header(input logic [LEN_W-1:0] len,
                                             input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [7:0] parity_fold(input logic [7:0] acc,
                                             input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload staging buffer: synchronous write, combinational read, contents
// deliberately left unreset.
module router_pkt_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_r [DEPTH];

  // Payload byte write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload from the byte source, then
// emits header, payload and XOR parity under the router's busy back-pressure.
module router_pkt_tx
  import router_defs::*;
#(
  parameter int MAX_LEN = 63
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              tx_busy,
  output logic              done,
  output logic              err_cfg,
  output logic [7:0]        pkt_count
);

  tx_state_t         state_r, state_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [LEN_W-1:0]  len_r, len_nxt_s;
  logic [LEN_W-1:0]  wr_idx_r, wr_idx_nxt_s, wr_idx_inc_s;
  logic [LEN_W-1:0]  rd_idx_r, rd_idx_nxt_s;
  logic [7:0]        parity_r, parity_nxt_s, parity_beat_s;
  logic [7:0]        data_out_r, data_nxt_s;
  logic              pkt_valid_r, pkt_valid_nxt_s;
  logic              done_r, done_nxt_s;
  logic              err_cfg_r, err_cfg_nxt_s;
  logic [7:0]        pkt_count_r, pkt_count_nxt_s;
  logic              src_ready_r, tx_busy_r;
  logic              wr_en_s;
  logic [7:0]        buf_rd_s;

  router_pkt_buf #(
    .DEPTH (MAX_LEN + 1),
    .AW    (LEN_W)
  ) u_buf (
    .clock   (clock),
    .wr_en   (wr_en_s),
    .wr_addr (wr_idx_r),
    .wr_data (src_data),
    .rd_addr (rd_idx_r),
    .rd_data (buf_rd_s)
  );

  assign wr_idx_inc_s  = wr_idx_r + 6'd1;
  assign parity_beat_s = parity_fold(parity_r, src_data);

  // Next-state and next-register-value decode
  always_comb begin
    state_nxt_s     = state_r;
    addr_nxt_s      = addr_r;
    len_nxt_s       = len_r;
    wr_idx_nxt_s    = wr_idx_r;
    rd_idx_nxt_s    = rd_idx_r;
    parity_nxt_s    = parity_r;
    data_nxt_s      = data_out_r;
    pkt_valid_nxt_s = pkt_valid_r;
    done_nxt_s      = 1'b0;
    err_cfg_nxt_s   = 1'b0;
    pkt_count_nxt_s = pkt_count_r;
    wr_en_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((dest_addr == ADDR_INVALID) || (payload_len == 6'd0)) begin
            err_cfg_nxt_s = 1'b1;
          end else begin
            addr_nxt_s   = dest_addr;
            len_nxt_s    = payload_len;
            wr_idx_nxt_s = 6'd0;
            rd_idx_nxt_s = 6'd0;
            parity_nxt_s = 8'd0;
            state_nxt_s  = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (src_valid) begin
          wr_en_s      = 1'b1;
          wr_idx_nxt_s = wr_idx_inc_s;
          // The header is folded into parity on the same beat it is launched
          if (wr_idx_inc_s == len_r) begin
            data_nxt_s      = make_header(len_r, addr_r);
            pkt_valid_nxt_s = 1'b1;
            parity_nxt_s    = parity_fold(parity_beat_s, make_header(len_r, addr_r));
            state_nxt_s     = ST_HEADER;
          end else begin
            parity_nxt_s = parity_beat_s;
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_HEADER: begin
        if (!busy) begin
          data_nxt_s   = buf_rd_s;
          rd_idx_nxt_s = 6'd1;
          state_nxt_s  = ST_PAYLOAD;
        end else begin
          state_nxt_s = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (!busy) begin
          if (rd_idx_r == len_r) begin
            data_nxt_s      = parity_r;
            pkt_valid_nxt_s = 1'b0;
            state_nxt_s     = ST_PARITY;
          end else begin
            data_nxt_s   = buf_rd_s;
            rd_idx_nxt_s = rd_idx_r + 6'd1;
          end
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_PARITY: begin
        if (!busy) begin
          data_nxt_s      = 8'd0;
          done_nxt_s      = 1'b1;
          pkt_count_nxt_s = pkt_count_r + 8'd1;
          state_nxt_s     = ST_DONE;
        end else begin
          state_nxt_s = ST_PARITY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counters, parity accumulator and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      addr_r      <= 2'd0;
      len_r       <= 6'd0;
      wr_idx_r    <= 6'd0;
      rd_idx_r    <= 6'd0;
      parity_r    <= 8'd0;
      data_out_r  <= 8'd0;
      pkt_valid_r <= 1'b0;
      done_r      <= 1'b0;
      err_cfg_r   <= 1'b0;
      pkt_count_r <= 8'd0;
      src_ready_r <= 1'b0;
      tx_busy_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      addr_r      <= addr_nxt_s;
      len_r       <= len_nxt_s;
      wr_idx_r    <= wr_idx_nxt_s;
      rd_idx_r    <= rd_idx_nxt_s;
      parity_r    <= parity_nxt_s;
      data_out_r  <= data_nxt_s;
      pkt_valid_r <= pkt_valid_nxt_s;
      done_r      <= done_nxt_s;
      err_cfg_r   <= err_cfg_nxt_s;
      pkt_count_r <= pkt_count_nxt_s;
      src_ready_r <= (state_nxt_s == ST_FILL);
      tx_busy_r   <= (state_nxt_s != ST_IDLE);
    end
  end

  assign src_ready = src_ready_r;
  assign pkt_valid = pkt_valid_r;
  assign data_out  = data_out_r;
  assign tx_busy   = tx_busy_r;
  assign done      = done_r;
  assign err_cfg   = err_cfg_r;
  assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx: framing, stalls, config
// rejection, maximum length, mid-packet reset, FILL gaps and stray start.
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] dest_addr;
  logic [5:0] payload_len;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_busy;
  logic       done;
  logic       err_cfg;
  logic [7:0] pkt_count;

  int total;
  int bad;
  int exp_count;
  logic [7:0] pl [64];

  router_pkt_tx dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .busy        (busy),
    .pkt_valid   (pkt_valid),
    .data_out    (data_out),
    .tx_busy     (tx_busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .pkt_count   (pkt_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sends one packet from pl[], checking every emitted byte against hdr/pl/par.
  task automatic send_pkt(input logic [1:0] a, input int n, input logic [7:0] hdr,
                          input logic [7:0] par, input int gap_beat, input int stall_j,
                          input int stall_n, input int xstart_j, input int abort_j);
    logic [7:0] ex;
    start = 1'b1; dest_addr = a; payload_len = n[5:0];
    step();
    start = 1'b0;
    check_eq("tx_busy_after_start", {31'd0, tx_busy}, 32'd1);
    check_eq("src_ready_in_fill", {31'd0, src_ready}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i == gap_beat) begin
        src_valid = 1'b0;
        step();
        check_eq("gap_src_ready", {31'd0, src_ready}, 32'd1);
        check_eq("gap_no_header", {31'd0, pkt_valid}, 32'd0);
      end
      src_valid = 1'b1; src_data = pl[i];
      step();
    end
    src_valid = 1'b0;
    check_eq("src_ready_low_after_fill", {31'd0, src_ready}, 32'd0);
    for (int j = 0; j <= n + 1; j++) begin
      if (j == 0) ex = hdr;
      else if (j <= n) ex = pl[j-1];
      else ex = par;
      check_eq("data_out_byte", {24'd0, data_out}, {24'd0, ex});
      check_eq("pkt_valid_frame", {31'd0, pkt_valid}, (j <= n) ? 32'd1 : 32'd0);
      if (j == abort_j) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_count = 0;
        check_eq("abort_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        check_eq("abort_data_out", {24'd0, data_out}, 32'd0);
        check_eq("abort_tx_busy", {31'd0, tx_busy}, 32'd0);
        check_eq("abort_pkt_count", {24'd0, pkt_count}, 32'd0);
        return;
      end
      if (j == stall_j) begin
        busy = 1'b1;
        repeat (stall_n) begin
          step();
          check_eq("stall_hold_data", {24'd0, data_out}, {24'd0, ex});
          check_eq("stall_hold_valid", {31'd0, pkt_valid}, (j <= n) ? 32'd1 : 32'd0);
        end
        busy = 1'b0;
      end
      if (j == xstart_j) begin
        start = 1'b1; dest_addr = 2'd0; payload_len = 6'd1;
      end
      step();
      start = 1'b0;
    end
    exp_count++;
    check_eq("done_pulse", {31'd0, done}, 32'd1);
    check_eq("pkt_count", {24'd0, pkt_count}, exp_count[31:0] & 32'hFF);
    check_eq("data_out_cleared", {24'd0, data_out}, 32'd0);
    step();
    check_eq("done_low", {31'd0, done}, 32'd0);
    check_eq("tx_busy_idle", {31'd0, tx_busy}, 32'd0);
  endtask

  initial begin
    total = 0; bad = 0; exp_count = 0;
    reset = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0;
    src_data = 8'd0; src_valid = 1'b0; busy = 1'b0;
    step();
    step();
    check_eq("rst_data_out", {24'd0, data_out}, 32'd0);
    check_eq("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    check_eq("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check_eq("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_err_cfg", {31'd0, err_cfg}, 32'd0);
    check_eq("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
    reset = 1'b0;
    step();

    // Basic packet: header 0D, parity DD
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_pkt(2'd1, 3, 8'h0D, 8'hDD, -1, -1, 0, -1, -1);

    // Same packet with a 2-cycle stall while B2 is shown
    send_pkt(2'd1, 3, 8'h0D, 8'hDD, -1, 2, 2, -1, -1);

    // Invalid configurations are rejected
    start = 1'b1; dest_addr = 2'd3; payload_len = 6'd5;
    step();
    start = 1'b0;
    check_eq("err_addr3", {31'd0, err_cfg}, 32'd1);
    check_eq("err_addr3_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("err_addr3_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    step();
    check_eq("err_pulse_end", {31'd0, err_cfg}, 32'd0);
    start = 1'b1; dest_addr = 2'd1; payload_len = 6'd0;
    step();
    start = 1'b0;
    check_eq("err_len0", {31'd0, err_cfg}, 32'd1);
    check_eq("err_len0_tx_busy", {31'd0, tx_busy}, 32'd0);
    check_eq("err_len0_pkt_valid", {31'd0, pkt_valid}, 32'd0);
    step();
    check_eq("err_pkt_count", {24'd0, pkt_count}, 32'd2);
    check_eq("err_len0_end", {31'd0, err_cfg}, 32'd0);

    // Maximum length: payload 00..3E, header FE, parity FE^3F = C1
    for (int i = 0; i < 63; i++) pl[i] = i[7:0];
    send_pkt(2'd2, 63, 8'hFE, 8'hC1, -1, -1, 0, -1, -1);

    // Reset while the 2nd payload byte is shown, then a full packet
    pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3;
    send_pkt(2'd1, 3, 8'h0D, 8'hDD, -1, -1, 0, -1, 2);
    step();
    send_pkt(2'd1, 3, 8'h0D, 8'hDD, -1, -1, 0, -1, -1);

    // FILL gap before beat 1 and a stray start during PAYLOAD: header 10, parity 54
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
    send_pkt(2'd0, 4, 8'h10, 8'h54, 1, -1, 0, 2, -1);
    step();
    check_eq("stray_start_ignored", {31'd0, tx_busy}, 32'd0);
    check_eq("final_pkt_count", {24'd0, pkt_count}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter driving the input side of the 1x3 router. It collects a payload from an upstream byte source into an internal buffer, then emits a framed router packet: header `{len, addr}`, payload bytes, and an even-XOR parity byte. It obeys the router's `busy` back-pressure and matches the router's `pkt_valid` framing. It is used as the stimulus and source block ahead of the router top.

## Interface
- `MAX_LEN`, 63: maximum payload bytes; sets the buffer depth and the 6-bit length field.
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request to send one packet; sampled only in IDLE.
- `dest_addr`  in  2: destination port 0..2; value 3 is invalid.
- `payload_len`  in  6: payload byte count 1..63; value 0 is invalid.
- `src_data`  in  8: upstream payload byte.
- `src_valid`  in  1: `src_data` is valid.
- `src_ready`  out  1: block accepts `src_data` this cycle.
- `busy`  in  1: router back-pressure; the current `data_out` byte is not taken while high.
- `pkt_valid`  out  1: framing to the router; high for header and payload, low for parity.
- `data_out`  out  8: byte to the router, registered.
- `tx_busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse after the parity byte is accepted.
- `err_cfg`  out  1: one-cycle pulse when `start` is rejected.
- `pkt_count`  out  8: count of packets completed; wraps at 255 to 0.

## Operation
- States: IDLE, FILL, HEADER, PAYLOAD, PARITY, DONE.
- **IDLE**
  - `start` with valid config: latch `addr` and `len`, clear `wr_idx` and `rd_idx`, then go to FILL.
  - `start` with `dest_addr`==3 or `payload_len`==0: pulse `err_cfg` and stay in IDLE.
  - `start` is ignored in every other state.
- **FILL**
  - `src_ready`=1 only in this state.
  - Each `src_valid`&`src_ready` beat writes `buf[wr_idx]`, XORs the byte into the parity accumulator, and increments `wr_idx`.
  - On the beat that makes `wr_idx`==`len`: `data_out`<=header=`{len,addr}`, `pkt_valid`<=1, parity accumulator ^= header, go to HEADER.
- **Transfer rule:** a byte on `data_out` is accepted at a rising edge where `busy`==0. While `busy`=1, `data_out` and `pkt_valid` hold.
- **HEADER**, on accept: `data_out`<=`buf[0]`, `rd_idx`<=1, go to PAYLOAD.
- **PAYLOAD**, on accept:
  - if `rd_idx`==`len`: `data_out`<=parity, `pkt_valid`<=0, go to PARITY.
  - otherwise: `data_out`<=`buf[rd_idx]`, `rd_idx`++.
- **PARITY**, on accept: `data_out`<=0, `done`<=1, `pkt_count`++, go to DONE.
- **DONE:** `done` deasserts, go to IDLE. A new `start` is accepted from the cycle after that.
- Parity = header XOR every payload byte, 8-bit.
- Reset values: state IDLE; `pkt_valid`, `data_out`, `src_ready`, `tx_busy`, `done`, `err_cfg` = 0; `pkt_count`=0; indices and parity accumulator = 0. Buffer contents are not reset.
- Reset mid-packet returns to IDLE on the next edge and drops `pkt_valid` at once. No partial-packet recovery; router soft reset handles that case.

## Timing
- Start accepted at edge E0. With `src_valid` held high, FILL beats occur at E1..E_len, and the header is on `data_out` after E_len.
- With `busy`=0 throughout:
  - payload byte k appears after E_(len+1+k);
  - parity appears after E_(2len+1);
  - `done` is high for the cycle after E_(2len+2).
- Every `busy` stall cycle adds one cycle. `src_valid` gaps during FILL add one cycle each.
- `pkt_valid` is high for exactly len+1 accepted bytes and falls the same edge parity is driven.

## Structure
- Shared definitions file `router_defs`: state encodings, header field widths (ADDR_W=2, LEN_W=6), and the invalid-address constant.
- Sub-module `router_pkt_buf`: MAX_LEN+1 x 8 storage, synchronous write, combinational read, no reset.
- The FSM, counters and parity accumulator live in the top module.

## Test plan
- `start`, addr=1, len=3, payload A1,B2,C3, `busy`=0 -> `data_out` sequence 0D,A1,B2,C3,DD; `pkt_valid` 1,1,1,1,0; one `done` pulse; `pkt_count`=1.
- Same packet with `busy`=1 for 2 cycles while B2 is shown -> B2 held 3 cycles, no byte skipped or duplicated, parity still DD.
- `start` with addr=3, then with len=0 -> `err_cfg` pulse each time; `tx_busy` and `pkt_valid` stay 0; `pkt_count` unchanged.
- addr=2, len=63, payload 00..3E -> header FE; 65 bytes emitted; parity = FE XOR (00^..^3E); `src_ready` low after the 63rd beat.
- `reset` asserted while the 2nd payload byte is on `data_out` -> next edge: IDLE, `pkt_valid`=0, `data_out`=0; a following `start` sends a full correct packet.
- `start` pulsed during PAYLOAD, and `src_valid` gapped 1 cycle in FILL -> the extra `start` is ignored; the gap delays the header by 1 cycle and data is unchanged.
